// File: rtl/bht_sat2_predictor_pkg.sv
// ---------------------------------------------------------------------------
// bht_sat2_predictor_pkg
// Shared types and helpers for the 2-bit saturating branch history table.
//   bht_cnt_e    : named counter states (strong/weak not-taken/taken)
//   bht_entry_t  : one table entry, a valid bit plus the 2-bit counter
//   BHT_CNT_RST  : counter value loaded on reset and on flush (weakly not-taken)
//   sat2_next()  : saturating counter step for a resolved branch direction
// ---------------------------------------------------------------------------
package bht_sat2_predictor_pkg;

  typedef enum logic [1:0] {
    CNT_STRONG_NT = 2'b00,
    CNT_WEAK_NT   = 2'b01,
    CNT_WEAK_T    = 2'b10,
    CNT_STRONG_T  = 2'b11
  } bht_cnt_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } bht_entry_t;

  localparam logic [1:0] BHT_CNT_RST = 2'b01;

  // Moves one step toward the resolved direction and holds at either end,
  // so a long run of one direction never wraps into the opposite prediction.
  function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_STRONG_T) res = cnt + 2'b01;
    end else begin
      if (cnt != CNT_STRONG_NT) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_sat2_predictor.sv
// ---------------------------------------------------------------------------
// bht_sat2_predictor
// Branch history table of 2-bit saturating counters held in flops.
// Lookup is combinational from the fetch PC; training arrives from the
// branch unit and is written at the next rising edge.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : invalidate every entry at the next edge (beats updates)
//   debug_mode_i    : while high, updates are ignored
//   vpc_i           : fetch PC to predict
//   pred_valid_o    : addressed entry has been trained
//   pred_taken_o    : prediction is taken (valid and counter MSB)
//   upd_valid_i     : one-cycle pulse carrying a resolved conditional branch
//   upd_pc_i        : PC of the resolved branch
//   upd_taken_i     : resolved direction
// ---------------------------------------------------------------------------
module bht_sat2_predictor
  import bht_sat2_predictor_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 128,
  parameter int unsigned VLEN       = 32,
  parameter int unsigned INDEX_LSB  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

  bht_entry_t bht_q [NR_ENTRIES];
  bht_entry_t bht_d [NR_ENTRIES];

  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;

  // Upper PC bits and the sub-word offset are deliberately dropped from the
  // index; aliasing between distant branches is accepted.
  assign lkp_idx = vpc_i[INDEX_LSB+IDX_W-1:INDEX_LSB];
  assign upd_idx = upd_pc_i[INDEX_LSB+IDX_W-1:INDEX_LSB];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i[VLEN-1:INDEX_LSB+IDX_W], vpc_i[INDEX_LSB-1:0],
                            upd_pc_i[VLEN-1:INDEX_LSB+IDX_W], upd_pc_i[INDEX_LSB-1:0]};

  // Lookup reads the registered table only, so an update to the same index in
  // this cycle is not visible until the next one.
  assign pred_valid_o = bht_q[lkp_idx].valid;
  assign pred_taken_o = bht_q[lkp_idx].valid & bht_q[lkp_idx].cnt[1];

  // Next-state of the table: flush wins over training; a first update to an
  // untrained entry seeds it at the weak state of the resolved direction
  // rather than stepping from the reset value.
  always_comb begin
    bht_d = bht_q;
    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        bht_d[i].valid = 1'b0;
        bht_d[i].cnt   = BHT_CNT_RST;
      end
    end else if (upd_valid_i && !debug_mode_i) begin
      if (!bht_q[upd_idx].valid) begin
        bht_d[upd_idx].valid = 1'b1;
        bht_d[upd_idx].cnt   = upd_taken_i ? CNT_WEAK_T : CNT_WEAK_NT;
      end else begin
        bht_d[upd_idx].cnt = sat2_next(bht_q[upd_idx].cnt, upd_taken_i);
      end
    end
  end

  // Table storage; reset clears every entry immediately, dropping any update
  // that was in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        bht_q[i].valid <= 1'b0;
        bht_q[i].cnt   <= BHT_CNT_RST;
      end
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bht_sat2_predictor.sv
// ---------------------------------------------------------------------------
// tb_bht_sat2_predictor
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a small array-based model of the table.
// ---------------------------------------------------------------------------
module tb_bht_sat2_predictor;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        debugMode;
  logic [31:0] vpc;
  logic        predValid;
  logic        predTaken;
  logic        updValid;
  logic [31:0] updPc;
  logic        updTaken;

  int checks   = 0;
  int failures = 0;

  // Reference model: counter value 0..3 and a trained flag per entry.
  int refCnt   [128];
  bit refValid [128];

  bht_sat2_predictor #(
    .NR_ENTRIES(128),
    .VLEN      (32),
    .INDEX_LSB (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .flush_i     (flush),
    .debug_mode_i(debugMode),
    .vpc_i       (vpc),
    .pred_valid_o(predValid),
    .pred_taken_o(predTaken),
    .upd_valid_i (updValid),
    .upd_pc_i    (updPc),
    .upd_taken_i (updTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with the expected value and logs a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pcIdx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h7f);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 128; i++) begin
      refValid[i] = 1'b0;
      refCnt[i]   = 1;
    end
  endtask

  // Drives one cycle of inputs at the falling edge, checks the combinational
  // prediction against the model (pre-update contents), then lets the rising
  // edge happen and advances the model.
  task automatic applyStimulus(input logic [31:0] lookupPc, input bit uValid,
                               input logic [31:0] uPc, input bit uTaken,
                               input bit fl, input bit dbg);
    int li;
    int ui;
    @(negedge clk);
    vpc       = lookupPc;
    updValid  = uValid;
    updPc     = uPc;
    updTaken  = uTaken;
    flush     = fl;
    debugMode = dbg;
    #1;
    li = pcIdx(lookupPc);
    checkOutput("pred_valid", 32'(predValid), 32'(refValid[li]));
    checkOutput("pred_taken", 32'(predTaken), 32'(refValid[li] && refCnt[li] >= 2));
    @(posedge clk);
    if (fl) begin
      modelReset();
    end else if (uValid && !dbg) begin
      ui = pcIdx(uPc);
      if (!refValid[ui]) begin
        refValid[ui] = 1'b1;
        refCnt[ui]   = uTaken ? 2 : 1;
      end else if (uTaken) begin
        refCnt[ui] = (refCnt[ui] + 1 > 3) ? 3 : refCnt[ui] + 1;
      end else begin
        refCnt[ui] = (refCnt[ui] - 1 < 0) ? 0 : refCnt[ui] - 1;
      end
    end
  endtask

  // Lookup-only cycle that also checks fixed expected outputs.
  task automatic lookupExpect(input string tag, input logic [31:0] pc,
                              input bit expValid, input bit expTaken);
    applyStimulus(pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_valid"}, 32'(predValid), 32'(expValid));
    checkOutput({tag, "_taken"}, 32'(predTaken), 32'(expTaken));
  endtask

  localparam logic [31:0] PC4     = 32'h8000_0010;
  localparam logic [31:0] PC4_ALI = 32'h8000_0210;
  localparam logic [31:0] PC7     = 32'h8000_001c;

  initial begin
    logic [31:0] rPc;
    logic [31:0] rLk;
    rstN = 1'b0; flush = 1'b0; debugMode = 1'b0; vpc = 32'h8000_0000;
    updValid = 1'b0; updPc = 32'h0; updTaken = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_valid", 32'(predValid), 32'h0);
    checkOutput("reset_taken", 32'(predTaken), 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    lookupExpect("post_reset", 32'h8000_0000, 1'b0, 1'b0);

    // First taken update seeds weakly taken; more takens saturate high.
    applyStimulus(PC4, 1'b1, PC4, 1'b1, 1'b0, 1'b0);
    lookupExpect("first_taken", PC4, 1'b1, 1'b1);
    repeat (3) applyStimulus(PC4, 1'b1, PC4, 1'b1, 1'b0, 1'b0);
    lookupExpect("sat_high", PC4, 1'b1, 1'b1);

    // From strongly taken, two not-takens reach weakly not-taken.
    applyStimulus(PC4, 1'b1, PC4, 1'b0, 1'b0, 1'b0);
    lookupExpect("nt_once", PC4, 1'b1, 1'b1);
    applyStimulus(PC4, 1'b1, PC4, 1'b0, 1'b0, 1'b0);
    lookupExpect("nt_twice", PC4, 1'b1, 1'b0);
    repeat (3) applyStimulus(PC4, 1'b1, PC4, 1'b0, 1'b0, 1'b0);
    // Saturated low: a single taken must only reach weakly not-taken.
    applyStimulus(PC4, 1'b1, PC4, 1'b1, 1'b0, 1'b0);
    lookupExpect("sat_low", PC4, 1'b1, 1'b0);

    // Entry is now weakly not-taken: same-cycle update is not bypassed.
    applyStimulus(PC4, 1'b1, PC4, 1'b1, 1'b0, 1'b0);
    checkOutput("no_bypass", 32'(predTaken), 32'h0);
    lookupExpect("after_bypass", PC4, 1'b1, 1'b1);

    // Aliasing: a PC differing only above the index hits the same entry.
    lookupExpect("alias", PC4_ALI, 1'b1, 1'b1);

    // Debug mode suppresses training of an untrained entry.
    applyStimulus(PC7, 1'b1, PC7, 1'b1, 1'b0, 1'b1);
    lookupExpect("debug_ignored", PC7, 1'b0, 1'b0);

    // Flush beats a coincident update; lookup in the flush cycle sees old data.
    applyStimulus(PC4, 1'b1, PC7, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_cycle_taken", 32'(predTaken), 32'h1);
    lookupExpect("flush_idx7", PC7, 1'b0, 1'b0);
    lookupExpect("flush_idx4", PC4, 1'b0, 1'b0);

    // Asynchronous reset mid-sequence clears outputs without waiting for an edge.
    applyStimulus(PC4, 1'b1, PC4, 1'b1, 1'b0, 1'b0);
    applyStimulus(PC4, 1'b1, PC4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    updValid = 1'b0;
    #2;
    checkOutput("pre_async_taken", 32'(predTaken), 32'h1);
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(predValid), 32'h0);
    checkOutput("async_rst_taken", 32'(predTaken), 32'h0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;

    // Random traffic over a small index window with random upper PC bits.
    for (int n = 0; n < 400; n++) begin
      rPc = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 7)) << 9);
      rLk = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 7)) << 9);
      applyStimulus(rLk, ($urandom_range(0, 3) != 0), rPc, 1'($urandom),
                    ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bht_sat2_predictor.md
Name: bht_sat2_predictor

Overview:
- Branch history table with 2-bit saturating counters for the cv32a6 frontend.
- Sized from the core configuration: BHTEntries = 128, VLEN = 32, RVC disabled, so predictions are at 4-byte granularity.
- Predicts direction for a conditional branch at the fetch PC. Trained from resolved branches out of the execute stage.
- Sits between the frontend PC generation (consumer) and the branch unit (producer of updates).

Parameters:
- NR_ENTRIES, 128, number of counters; power of two, >= 2.
- VLEN, 32, virtual address width.
- INDEX_LSB, 2, lowest PC bit used in the index (2 since RVC is off).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  invalidate all entries (sfence/fence.i, or a mode change)
- debug_mode_i  in  1  core in debug mode; suppresses training
- vpc_i  in  VLEN  fetch PC to predict
- pred_valid_o  out  1  addressed entry holds a trained counter
- pred_taken_o  out  1  predicted taken (counter MSB)
- upd_valid_i  in  1  resolved conditional branch update, single-cycle pulse
- upd_pc_i  in  VLEN  PC of the resolved branch
- upd_taken_i  in  1  resolved direction

Behaviour:
- Index: idx = pc[INDEX_LSB+log2(NR_ENTRIES)-1 : INDEX_LSB]. Upper PC bits are ignored; aliasing is permitted.
- Storage: per entry, a valid bit and cnt[1:0]. Flop array, not SRAM.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Reset (async, rst_ni=0): all valid=0, all cnt=01. Outputs therefore reset to pred_valid_o=0, pred_taken_o=0.
- Lookup: combinational, zero latency.
  - pred_valid_o = valid[idx(vpc_i)].
  - pred_taken_o = valid & cnt[1].
- Update: takes effect at the next rising edge.
  - Entry invalid: valid<=1; cnt <= upd_taken_i ? 10 : 01.
  - Entry valid and taken: cnt <= (cnt==11) ? 11 : cnt+1.
  - Entry valid and not taken: cnt <= (cnt==00) ? 00 : cnt-1.
- Saturation: no wrap at either end. 11 plus taken stays 11; 00 plus not-taken stays 00.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value. No bypass.
- debug_mode_i=1: updates are ignored. Lookups continue normally.
- flush_i=1: at the next edge all valid<=0 and cnt<=01.
  - Flush takes priority over a coincident update; the update is dropped.
  - Lookups in the flush cycle still return pre-flush contents.
- Reset asserted mid-operation: state clears immediately (asynchronous). Any pending update is lost.
- No backpressure: an update is accepted every cycle it is valid. No internal FSM beyond the per-entry counter state machine.

Decomposition:
- Shared package (cva6 core package):
  - bht_entry_t struct {logic valid; logic [1:0] cnt;}
  - Constant BHT_CNT_RST = 2'b01.
  - Function sat2_next(cnt, taken) implementing the saturating update.
- No sub-module. The counter update is the package function; the array and index logic live in bht_sat2_predictor.

Test Plan:
- Reset, then drive vpc_i=0x8000_0000 -> pred_valid_o=0, pred_taken_o=0.
- One taken update at pc 0x8000_0010 (idx 4); next cycle lookup 0x8000_0010 -> valid=1, taken=1, cnt=10. Three more taken updates -> cnt stays 11.
- From cnt=11 at idx 4, two not-taken updates -> cnt=01, pred_taken_o=0. Two more not-taken updates -> cnt=00 and stays there.
- Aliasing: update taken at 0x8000_0010, then look up 0x8000_0210 (same idx for NR_ENTRIES=128) -> pred_taken_o=1.
- Simultaneous lookup and update at idx 4 (cnt=01, taken) -> same cycle pred_taken_o=0, next cycle 1.
- Coincident events:
  - flush_i with upd_valid_i at idx 7 -> next cycle all entries invalid, idx 7 invalid.
  - debug_mode_i=1 with a taken update -> entry unchanged.
  - rst_ni pulled low mid-sequence -> outputs 0 immediately.
